// File: rtl/debug_tx_queue_pkg.sv
// Shared constants and state encodings for the debug peripheral transmit queue.
package debug_tx_queue_pkg;

    localparam int TXQ_DEPTH_LOG2_DEFAULT = 8;
    localparam int TXQ_DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        s_TXQ_IDLE = 2'd0,
        s_TXQ_SEND = 2'd1,
        s_TXQ_GAP  = 2'd2
    } txq_state_e;

endpackage

// File: rtl/debug_tx_queue_mem.sv
// Queue storage: DEPTH x DATA_WIDTH RAM, one synchronous write port, one asynchronous read port.
module debug_tx_queue_mem
    import debug_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT,
    parameter int DATA_WIDTH = TXQ_DATA_WIDTH_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // No reset: contents are don't-care, which keeps this mappable to distributed RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_tx_queue.sv
// Byte queue and transmit sequencer between the debug command logic and the UART transmitter.
module debug_tx_queue
    import debug_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT,
    parameter int DATA_WIDTH = TXQ_DATA_WIDTH_DEFAULT
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Push,
    input  logic [DATA_WIDTH-1:0] i_Push_Byte,
    input  logic                  i_Flush,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Tx_DV,
    output logic [DATA_WIDTH-1:0] o_Tx_Byte,
    input  logic                  i_Tx_Done
);

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

    txq_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  txDv_q, txDv_d;
    logic [DATA_WIDTH-1:0] txByte_q, txByte_d;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  full;
    logic                  pop;
    logic                  pushAccept;

    debug_tx_queue_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk_i   (i_Clock),
        .we_i    (pushAccept),
        .waddr_i (head_q),
        .wdata_i (i_Push_Byte),
        .raddr_i (tail_q),
        .rdata_o (rdData)
    );

    assign full = (count_q == FULL_COUNT);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= s_TXQ_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            txDv_q     <= 1'b0;
            txByte_q   <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            txDv_q     <= txDv_d;
            txByte_q   <= txByte_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        txDv_d     = txDv_q;
        txByte_d   = txByte_q;
        pop        = 1'b0;
        pushAccept = 1'b0;

        // A flush in IDLE suppresses the load; a byte already in SEND always completes.
        unique case (state_q)
            s_TXQ_IDLE: begin
                if ((count_q != '0) && !i_Flush) begin
                    pop      = 1'b1;
                    txByte_d = rdData;
                    txDv_d   = 1'b1;
                    state_d  = s_TXQ_SEND;
                end
            end
            s_TXQ_SEND: begin
                if (i_Tx_Done) begin
                    txDv_d   = 1'b0;
                    txByte_d = '0;
                    state_d  = s_TXQ_GAP;
                end
            end
            s_TXQ_GAP: begin
                state_d = s_TXQ_IDLE;
            end
            default: begin
                state_d = s_TXQ_IDLE;
            end
        endcase

        pushAccept = i_Push && !i_Flush && (!full || pop);

        if (i_Flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pushAccept) begin
                head_d = head_q + PTR_ONE;
            end
            if (pop) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pushAccept && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!pushAccept && pop) begin
                count_d = count_q - CNT_ONE;
            end
            if (i_Push && !pushAccept) begin
                overflow_d = 1'b1;
            end
        end
    end

    assign o_Full     = full;
    assign o_Empty    = (count_q == '0);
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_DV    = txDv_q;
    assign o_Tx_Byte  = txByte_q;

endmodule

// File: tb/tb_debug_tx_queue.sv
// Directed self-checking bench for debug_tx_queue with a simple transmitter model answering DV with Done.
module tb_debug_tx_queue;

    localparam int DL = 8;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          push;
    logic [DW-1:0] pushByte;
    logic          flush;
    logic          full;
    logic          empty;
    logic [DL:0]   count;
    logic          overflow;
    logic          txDv;
    logic [DW-1:0] txByte;
    logic          txDone = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Transmitter model state
    bit           doneEnable = 1'b0;
    int           doneDelay  = 20;
    int           dvCount    = 0;
    int           lowRun     = 0;
    bit           prevDv     = 1'b0;
    logic [DW-1:0] rxQ[$];
    int           gapQ[$];

    debug_tx_queue #(
        .DEPTH_LOG2 (DL),
        .DATA_WIDTH (DW)
    ) dut (
        .i_Clock     (clock),
        .i_Reset     (reset),
        .i_Push      (push),
        .i_Push_Byte (pushByte),
        .i_Flush     (flush),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_Tx_DV     (txDv),
        .o_Tx_Byte   (txByte),
        .i_Tx_Done   (txDone)
    );

    always #5 clock = ~clock;

    // Transmitter: raises Done after doneDelay DV-high cycles, logs bytes and DV-low run lengths.
    always @(negedge clock) begin
        if (reset) begin
            dvCount = 0;
            txDone  = 1'b0;
            prevDv  = 1'b0;
            lowRun  = 0;
        end else begin
            txDone = 1'b0;
            if (txDv && doneEnable) begin
                dvCount++;
                if (dvCount >= doneDelay) begin
                    txDone  = 1'b1;
                    dvCount = 0;
                    rxQ.push_back(txByte);
                end
            end else begin
                dvCount = 0;
            end
            if (txDv) begin
                if (!prevDv) gapQ.push_back(lowRun);
                lowRun = 0;
            end else begin
                lowRun++;
            end
            prevDv = txDv;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic doPush, input logic [DW-1:0] b, input logic doFlush);
        push     = doPush;
        pushByte = b;
        flush    = doFlush;
        tick();
        push  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic waitRx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rxQ.size() < n; i++) tick();
        checkOutput(tag, rxQ.size(), n);
    endtask

    initial begin
        int bad;
        int sent;
        logic [DW-1:0] expByte;

        reset    = 1'b1;
        push     = 1'b0;
        pushByte = '0;
        flush    = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_dv", txDv, 0);
        checkOutput("rst_byte", txByte, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_count", count, 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        $display("[TB] single byte latency");
        doneEnable = 1'b1;
        doneDelay  = 20;
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("t1_count_after_push", count, 1);
        checkOutput("t1_dv_not_yet", txDv, 0);
        checkOutput("t1_not_empty", empty, 0);
        tick();
        checkOutput("t1_dv_up", txDv, 1);
        checkOutput("t1_byte", txByte, 8'hA5);
        checkOutput("t1_count_zero", count, 0);
        checkOutput("t1_empty_again", empty, 1);
        waitRx("t1_rx_count", 1, 100);
        checkOutput("t1_dv_drop", txDv, 0);
        checkOutput("t1_byte_clear", txByte, 0);
        tick();
        checkOutput("t1_dv_gap", txDv, 0);
        checkOutput("t1_rx_byte", rxQ[0], 8'hA5);

        $display("[TB] ordering");
        rxQ.delete();
        gapQ.delete();
        push = 1'b1;
        pushByte = 8'h78; tick();
        pushByte = 8'h56; tick();
        pushByte = 8'h34; tick();
        pushByte = 8'h12; tick();
        push = 1'b0;
        waitRx("t2_rx_count", 4, 300);
        checkOutput("t2_b0", rxQ[0], 8'h78);
        checkOutput("t2_b1", rxQ[1], 8'h56);
        checkOutput("t2_b2", rxQ[2], 8'h34);
        checkOutput("t2_b3", rxQ[3], 8'h12);
        checkOutput("t2_rises", gapQ.size(), 4);
        // Between bytes DV is low for the GAP cycle plus the IDLE load cycle.
        checkOutput("t2_gap1", gapQ[1], 2);
        checkOutput("t2_gap2", gapQ[2], 2);
        checkOutput("t2_gap3", gapQ[3], 2);
        repeat (3) tick();

        $display("[TB] fill and overflow");
        doneEnable = 1'b0;
        rxQ.delete();
        push = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pushByte = DW'(i);
            tick();
        end
        push = 1'b0;
        checkOutput("t3_count_255", count, 255);
        checkOutput("t3_not_full", full, 0);
        checkOutput("t3_inflight_dv", txDv, 1);
        checkOutput("t3_inflight_byte", txByte, 8'h00);
        applyStimulus(1'b1, 8'h99, 1'b0);
        checkOutput("t3_count_256", count, 256);
        checkOutput("t3_full", full, 1);
        checkOutput("t3_no_ovf_yet", overflow, 0);
        applyStimulus(1'b1, 8'hBB, 1'b0);
        checkOutput("t3_ovf_set", overflow, 1);
        checkOutput("t3_count_held", count, 256);
        tick();
        checkOutput("t3_ovf_sticky", overflow, 1);
        doneDelay  = 1;
        doneEnable = 1'b1;
        waitRx("t3_rx_count", 257, 2000);
        repeat (5) tick();
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            expByte = (i < 256) ? DW'(i) : 8'h99;
            if (i >= rxQ.size() || rxQ[i] !== expByte) bad++;
        end
        checkOutput("t3_order_errors", bad, 0);
        checkOutput("t3_no_extra_bytes", rxQ.size(), 257);
        checkOutput("t3_drained_empty", empty, 1);
        checkOutput("t3_ovf_after_drain", overflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_flush_clears_ovf", overflow, 0);
        checkOutput("t3_flush_empty", empty, 1);

        $display("[TB] pointer wrap");
        rxQ.delete();
        sent = 0;
        for (int c = 0; c < 3000 && sent < 600; c++) begin
            if (!full) begin
                push     = 1'b1;
                pushByte = sent[DW-1:0];
                sent++;
            end else begin
                push = 1'b0;
            end
            tick();
        end
        push = 1'b0;
        checkOutput("t4_pushes", sent, 600);
        waitRx("t4_rx_count", 600, 3000);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            expByte = DW'(i % 256);
            if (i >= rxQ.size() || rxQ[i] !== expByte) bad++;
        end
        checkOutput("t4_order_errors", bad, 0);
        checkOutput("t4_no_ovf", overflow, 0);
        repeat (3) tick();
        checkOutput("t4_empty", empty, 1);

        $display("[TB] flush mid-send");
        rxQ.delete();
        doneDelay = 20;
        push = 1'b1;
        pushByte = 8'h11; tick();
        pushByte = 8'h22; tick();
        pushByte = 8'h33; tick();
        pushByte = 8'h44; tick();
        pushByte = 8'h55; tick();
        push = 1'b0;
        checkOutput("t5_count_4", count, 4);
        repeat (2) tick();
        applyStimulus(1'b1, 8'hEE, 1'b1);
        checkOutput("t5_count_flushed", count, 0);
        checkOutput("t5_empty", empty, 1);
        checkOutput("t5_no_ovf", overflow, 0);
        checkOutput("t5_dv_held", txDv, 1);
        checkOutput("t5_byte_held", txByte, 8'h11);
        waitRx("t5_rx_first", 1, 100);
        repeat (40) tick();
        checkOutput("t5_only_one_byte", rxQ.size(), 1);
        checkOutput("t5_rx_byte", rxQ[0], 8'h11);
        checkOutput("t5_dv_idle", txDv, 0);

        $display("[TB] async reset mid-byte");
        doneEnable = 1'b0;
        rxQ.delete();
        push = 1'b1;
        pushByte = 8'hA1; tick();
        pushByte = 8'hA2; tick();
        pushByte = 8'hA3; tick();
        pushByte = 8'hA4; tick();
        push = 1'b0;
        checkOutput("t6_count_3", count, 3);
        checkOutput("t6_dv_up", txDv, 1);
        checkOutput("t6_byte", txByte, 8'hA1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t6_async_dv", txDv, 0);
        checkOutput("t6_async_empty", empty, 1);
        checkOutput("t6_async_count", count, 0);
        checkOutput("t6_async_byte", txByte, 0);
        #2 reset = 1'b0;
        doneDelay  = 3;
        doneEnable = 1'b1;
        applyStimulus(1'b1, 8'hC3, 1'b0);
        waitRx("t6_rx_count", 1, 100);
        checkOutput("t6_rx_byte", rxQ[0], 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
